// File: rtl/mips_debug_pkg.sv
// Shared debug-unit definitions: dump FSM state encoding and stream geometry.
package mips_debug_pkg;

    localparam int NB_DATA        = 32;
    localparam int NB_BYTE        = 8;
    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int N_REGISTERS    = 32;
    localparam int NB_REGISTER    = 5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HALT_REQ = 3'd1,
        S_SELECT   = 3'd2,
        S_LATCH    = 3'd3,
        S_SEND     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one register word and presents it MSB-first, one byte at a time;
// advances on an accepted byte and flags the final byte of the word.
module word_byte_serializer #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    input  logic               i_advance,
    output logic [NB_BYTE-1:0] o_byte,
    output logic               o_last
);

    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int NB_BYTE_IDX    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [NB_BYTE_IDX-1:0] LAST_IDX = NB_BYTE_IDX'(BYTES_PER_WORD - 1);

    logic [NB_DATA-1:0]     capture;
    logic [NB_BYTE_IDX-1:0] byte_idx;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            capture  <= '0;
            byte_idx <= '0;
        end else if (i_load) begin
            capture  <= i_word;
            byte_idx <= '0;
        end else if (i_advance) begin
            capture  <= capture << NB_BYTE;
            byte_idx <= byte_idx + 1'b1;
        end
    end

    assign o_byte = capture[NB_DATA-1 -: NB_BYTE];
    assign o_last = (byte_idx == LAST_IDX);

endmodule

// File: rtl/register_dump_controller.sv
// Debug sequencer: halts the pipeline, borrows bank read port 0 and streams
// every register MSB-first over a valid/ready byte interface.
module register_dump_controller #(
    parameter int NB_DATA     = mips_debug_pkg::NB_DATA,
    parameter int N_REGISTERS = mips_debug_pkg::N_REGISTERS,
    parameter int NB_REGISTER = mips_debug_pkg::NB_REGISTER,
    parameter int NB_BYTE     = mips_debug_pkg::NB_BYTE
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_halted,
    output logic                   o_halt_req,
    output logic                   o_bank_grant,
    output logic                   o_bank_valid,
    output logic [NB_REGISTER-1:0] o_read_reg_sel,
    input  logic [NB_DATA-1:0]     i_read_reg_data,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output mips_debug_pkg::state_t o_state
);

    import mips_debug_pkg::*;

    // Handshake: a byte transfers on a posedge where o_tx_valid && i_tx_ready;
    // once raised, o_tx_valid and o_tx_data stay put until that transfer.

    localparam logic [NB_REGISTER-1:0] LAST_REG = NB_REGISTER'(N_REGISTERS - 1);

    state_t                 state;
    state_t                 state_next;
    logic [NB_REGISTER-1:0] reg_idx;
    logic                   reg_inc;
    logic                   reg_clr;
    logic                   load;
    logic                   advance;
    logic                   last_byte;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state   <= S_IDLE;
            reg_idx <= '0;
        end else begin
            state <= state_next;
            if (reg_clr)
                reg_idx <= '0;
            else if (reg_inc)
                reg_idx <= reg_idx + 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        o_halt_req     = 1'b0;
        o_bank_grant   = 1'b0;
        o_bank_valid   = 1'b0;
        o_read_reg_sel = '0;
        o_tx_valid     = 1'b0;
        o_busy         = 1'b1;
        o_done         = 1'b0;
        load           = 1'b0;
        advance        = 1'b0;
        reg_inc        = 1'b0;
        reg_clr        = 1'b0;
        case (state)
            S_IDLE: begin
                o_busy  = 1'b0;
                reg_clr = 1'b1;
                if (i_start)
                    state_next = S_HALT_REQ;
            end
            S_HALT_REQ: begin
                o_halt_req = 1'b1;
                if (i_halted)
                    state_next = S_SELECT;
            end
            S_SELECT: begin
                o_halt_req     = 1'b1;
                o_bank_grant   = 1'b1;
                o_bank_valid   = 1'b1;
                o_read_reg_sel = reg_idx;
                state_next     = S_LATCH;
            end
            S_LATCH: begin
                o_halt_req     = 1'b1;
                o_bank_grant   = 1'b1;
                o_bank_valid   = 1'b1;
                o_read_reg_sel = reg_idx;
                load           = 1'b1;
                state_next     = S_SEND;
            end
            S_SEND: begin
                o_halt_req     = 1'b1;
                o_bank_grant   = 1'b1;
                o_bank_valid   = 1'b1;
                o_read_reg_sel = reg_idx;
                o_tx_valid     = 1'b1;
                advance        = i_tx_ready;
                if (i_tx_ready && last_byte) begin
                    if (reg_idx == LAST_REG) begin
                        state_next = S_DONE;
                    end else begin
                        reg_inc    = 1'b1;
                        state_next = S_SELECT;
                    end
                end
            end
            S_DONE: begin
                o_halt_req     = 1'b1;
                o_bank_grant   = 1'b1;
                o_bank_valid   = 1'b1;
                o_read_reg_sel = reg_idx;
                o_done         = 1'b1;
                state_next     = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    word_byte_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_load    (load),
        .i_word    (i_read_reg_data),
        .i_advance (advance),
        .o_byte    (o_tx_data),
        .o_last    (last_byte)
    );

    assign o_state = state;

endmodule

// File: tb/tb_register_dump_controller.sv
// Scoreboard bench for register_dump_controller: expected bytes are queued at
// dump start, a negedge monitor pops and compares every accepted byte.
module tb_register_dump_controller;
  import mips_debug_pkg::*;

  logic         clk = 1'b0;
  logic         i_reset;
  logic         i_start;
  logic         i_halted;
  logic         o_halt_req;
  logic         o_bank_grant;
  logic         o_bank_valid;
  logic [4:0]   o_read_reg_sel;
  logic [31:0]  i_read_reg_data;
  logic [7:0]   o_tx_data;
  logic         o_tx_valid;
  logic         i_tx_ready;
  logic         o_busy;
  logic         o_done;
  state_t       o_state;

  logic [31:0]  bank [32];
  logic [7:0]   exp_q [$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           accepted = 0;
  int           done_count = 0;
  int           exp_done_cyc = -1;
  logic         rand_ready = 1'b0;
  logic         prev_hold = 1'b0;
  logic [7:0]   prev_data = 8'h00;
  logic         prev_done = 1'b0;
  logic [7:0]   last_byte = 8'h00;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign i_read_reg_data = bank[o_read_reg_sel];

  register_dump_controller dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_halted        (i_halted),
    .o_halt_req      (o_halt_req),
    .o_bank_grant    (o_bank_grant),
    .o_bank_valid    (o_bank_valid),
    .o_read_reg_sel  (o_read_reg_sel),
    .i_read_reg_data (i_read_reg_data),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .i_tx_ready      (i_tx_ready),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_state         (o_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) i_tx_ready = 1'($urandom_range(0, 1));
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (i_reset) begin
      if (prev_hold) check("hold_valid", 32'(o_tx_valid), 32'd1);
      if (prev_hold && o_tx_valid) check("hold_data", 32'(o_tx_data), 32'(prev_data));
      if (prev_done) check("busy_after_done", 32'(o_busy), 32'd0);
      if (o_tx_valid && i_tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%h required=none (cycle %0d)", o_tx_data, cyc);
        end else begin
          check("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
        end
        accepted++;
        last_byte = o_tx_data;
      end
      if (o_done) begin
        done_count++;
        if (exp_done_cyc >= 0) check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
      end
      if (o_bank_grant) check("sel_range", 32'(o_read_reg_sel <= 5'd31), 32'd1);
      prev_hold = o_tx_valid && !i_tx_ready;
      prev_data = o_tx_data;
      prev_done = o_done;
    end else begin
      prev_hold = 1'b0;
      prev_done = 1'b0;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = bank[i / 4];
      exp_q.push_back(w[8 * (3 - (i % 4)) +: 8]);
    end
  endtask

  task automatic start_dump(input int lat);
    i_start = 1'b1;
    exp_done_cyc = (lat >= 0) ? cyc + lat : -1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_halt_req"}, 32'(o_halt_req), 32'd0);
    check({name, "_grant"}, 32'(o_bank_grant), 32'd0);
    check({name, "_bank_valid"}, 32'(o_bank_valid), 32'd0);
    check({name, "_sel"}, 32'(o_read_reg_sel), 32'd0);
    check({name, "_tx_data"}, 32'(o_tx_data), 32'd0);
    check({name, "_tx_valid"}, 32'(o_tx_valid), 32'd0);
    check({name, "_busy"}, 32'(o_busy), 32'd0);
    check({name, "_done"}, 32'(o_done), 32'd0);
    check({name, "_state"}, 32'(o_state), 32'(S_IDLE));
  endtask

  initial begin
    int base;
    for (int k = 0; k < 32; k++) bank[k] = 32'h1111_0000 * 32'(k) + 32'(k);
    i_reset = 1'b0;
    i_start = 1'b0;
    i_halted = 1'b1;
    i_tx_ready = 1'b1;
    repeat (3) step();
    check_idle_outputs("reset");
    i_reset = 1'b1;
    step();

    // 1: full dump, ready always high, fixed latency
    push_bytes(128);
    start_dump(194);
    wait_done("s1_done_seen");
    step();
    check("s1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("s1_done_count", 32'(done_count), 32'd1);
    check("s1_busy", 32'(o_busy), 32'd0);

    // 2: halt acknowledge delayed
    i_halted = 1'b0;
    push_bytes(128);
    start_dump(-1);
    for (int i = 0; i < 10; i++) begin
      check("s2_halt_req", 32'(o_halt_req), 32'd1);
      check("s2_no_grant", 32'(o_bank_grant), 32'd0);
      check("s2_no_tx", 32'(o_tx_valid), 32'd0);
      step();
    end
    i_halted = 1'b1;
    wait_done("s2_done_seen");
    step();
    check("s2_queue_empty", 32'(exp_q.size()), 32'd0);
    check("s2_done_count", 32'(done_count), 32'd2);

    // 3: random backpressure
    rand_ready = 1'b1;
    push_bytes(128);
    start_dump(-1);
    wait_done("s3_done_seen");
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    i_tx_ready = 1'b1;
    step();
    check("s3_queue_empty", 32'(exp_q.size()), 32'd0);
    check("s3_done_count", 32'(done_count), 32'd3);

    // 4: reset during r[7] byte 2, then restart from r[0]
    base = accepted;
    push_bytes(30);
    start_dump(-1);
    for (int i = 0; i < 500; i++) begin
      if (accepted - base >= 30) break;
      step();
    end
    check("s4_reached_r7", 32'(accepted - base), 32'd30);
    check("s4_valid", 32'(o_tx_valid), 32'd1);
    check("s4_sel", 32'(o_read_reg_sel), 32'd7);
    check("s4_byte2", 32'(o_tx_data), 32'h00);
    i_tx_ready = 1'b0;
    i_reset = 1'b0;
    step();
    check_idle_outputs("s4_abort");
    check("s4_queue_empty", 32'(exp_q.size()), 32'd0);
    i_reset = 1'b1;
    i_tx_ready = 1'b1;
    repeat (3) step();
    check("s4_no_done", 32'(done_count), 32'd3);
    check("s4_idle_busy", 32'(o_busy), 32'd0);
    push_bytes(128);
    start_dump(194);
    wait_done("s4_done_seen");
    step();
    check("s4_restart_empty", 32'(exp_q.size()), 32'd0);
    check("s4_done_count", 32'(done_count), 32'd4);

    // 5: start pulses while busy and during DONE are ignored
    push_bytes(128);
    start_dump(194);
    repeat (37) step();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (50) step();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_done("s5_done_seen");
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("s5_state_idle", 32'(o_state), 32'(S_IDLE));
    repeat (3) begin
      check("s5_stays_idle", 32'(o_busy), 32'd0);
      step();
    end
    check("s5_queue_empty", 32'(exp_q.size()), 32'd0);
    check("s5_done_count", 32'(done_count), 32'd5);

    // 6: distinctive last register
    bank[31] = 32'hDEAD_BEEF;
    push_bytes(128);
    start_dump(194);
    wait_done("s6_done_seen");
    step();
    check("s6_queue_empty", 32'(exp_q.size()), 32'd0);
    check("s6_last_byte", 32'(last_byte), 32'hEF);
    check("s6_done_count", 32'(done_count), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
